fifo_hex_display: RTL
=====================

// Module: fifo_hex_display
// PURPOSE
//  Downstream consumer of the RAM->FIFO mover: pops 16-bit words from the FIFO (normal,
//  non-show-ahead mode), shows each word on four 7-segment digits for HOLD_PERIOD ms,
//  then pops the next. Paces display so every word moved out of RAM is visible to the user.
// PARAMETERS
//  CLK_FREQ        50000000  clock frequency, Hz
//  HOLD_PERIOD     1000      display time per word, ms; HOLD_TICKS = (CLK_FREQ/1000)*HOLD_PERIOD (>=1)
//  SEG_ACTIVE_LOW  1         1: segment on = 0 (DE-board HEX); 0: segment on = 1
// PORTS
//  clock        in   1   system clock, all logic on rising edge
//  rstn         in   1   synchronous, active-low reset
//  enable       in   1   1 = allowed to start new FIFO reads
//  fifo_rdreq   out  1   FIFO read request, registered, one-cycle pulse per word
//  fifo_q       in   16  FIFO read data, valid the cycle after rdreq sampled high
//  fifo_empty   in   1   FIFO empty flag
//  hex0..hex3   out  7   segments {g,f,e,d,c,b,a}; hex0 = data[3:0] ... hex3 = data[15:12]
//  word_valid   out  1   1 once at least one word captured since reset
//  word_count   out  8   number of words captured since reset, wraps 255->0
// BEHAVIOUR
//  Reset (rstn=0 at edge): state=IDLE, fifo_rdreq=0, data_reg=16'h0, word_valid=0,
//   word_count=0, hold counter=0; hex0..3 blank (all segments off: 7'h7F if active-low).
//  FSM states IDLE, REQ, CAPTURE, HOLD (all transitions on rising edge):
//   IDLE:    enable && !fifo_empty -> fifo_rdreq<=1, REQ; else stay, fifo_rdreq=0.
//   REQ:     fifo_rdreq<=0 -> CAPTURE (FIFO samples rdreq on this edge, updates q).
//   CAPTURE: data_reg<=fifo_q, word_valid<=1, word_count<=word_count+1, counter<=0 -> HOLD.
//   HOLD:    counter increments; when counter==HOLD_TICKS-1 -> IDLE, counter<=0.
//  fifo_rdreq is high for exactly one cycle per word; never asserted in REQ/CAPTURE/HOLD.
//  Latency: data_reg updates on the 2nd edge after the edge that raised fifo_rdreq.
//  Word period with FIFO continuously non-empty: HOLD_TICKS + 3 cycles.
//  fifo_empty/enable are examined only in IDLE; empty rising during REQ does not cancel.
//  enable deasserted mid-transaction: current word completes capture and hold; no new read.
//  Hex outputs: combinational decode of data_reg (registered source), 0-F hex glyphs;
//   blank while word_valid=0. Polarity inverted when SEG_ACTIVE_LOW=1.
//   Active-low codes: 0=0x40 1=0x79 2=0x24 3=0x30 4=0x19 5=0x12 6=0x02 7=0x78
//   8=0x00 9=0x10 A=0x08 b=0x03 C=0x46 d=0x21 E=0x06 F=0x0E.
//  Hold counter width $clog2(HOLD_TICKS)+1; HOLD_TICKS computed in 64-bit localparam.
//  Reset mid-operation (any state): immediate return to reset values; a word already
//   popped but not captured is dropped (accepted loss).
//  word_count wraps silently 8'hFF -> 8'h00; no saturation.
// TESTING  (bench params CLK_FREQ=1000, HOLD_PERIOD=4 -> HOLD_TICKS=4)
//  1 Reset: rstn=0 two cycles -> rdreq=0, word_valid=0, word_count=0, hex0..3=0x7F.
//  2 Single word: FIFO holds 16'h12AF, enable=1 -> rdreq 1 cycle; 2 edges later
//    hex3=0x79 hex2=0x24 hex1=0x08 hex0=0x0E, word_valid=1, word_count=1.
//  3 Pacing: FIFO holds 3 words, enable=1 -> rdreq pulses exactly 7 cycles apart,
//    word_count 1,2,3; no rdreq after FIFO empty.
//  4 Empty/enable gating: fifo_empty=1 or enable=0 for 50 cycles -> rdreq stays 0,
//    display holds last word; enable dropped during HOLD -> hold completes, no new rdreq.
//  5 Reset mid-REQ and mid-HOLD -> next edge all outputs at reset values, hex blank.
//  6 Wrap: 256 words streamed -> word_count reads 8'h00 after 256th capture.

Source files
------------

// File: rtl/fifo_hex_display_if.sv
// Bundle between the FIFO consumer and its environment: FIFO read port,
// enable, four 7-segment digits and word status.
interface fifo_hex_display_if;
  logic        enable;
  logic        fifo_rdreq;
  logic [15:0] fifo_q;
  logic        fifo_empty;
  logic [6:0]  hex0;
  logic [6:0]  hex1;
  logic [6:0]  hex2;
  logic [6:0]  hex3;
  logic        word_valid;
  logic [7:0]  word_count;

  modport master (
    output enable, fifo_q, fifo_empty,
    input  fifo_rdreq, hex0, hex1, hex2, hex3, word_valid, word_count
  );

  modport slave (
    input  enable, fifo_q, fifo_empty,
    output fifo_rdreq, hex0, hex1, hex2, hex3, word_valid, word_count
  );
endinterface

// File: rtl/fifo_hex_display.sv
// Pops 16-bit words from a normal-mode FIFO and shows each one on four hex
// digits for HOLD_PERIOD ms before fetching the next.
module fifo_hex_display #(
  parameter int unsigned CLK_FREQ       = 50000000,
  parameter int unsigned HOLD_PERIOD    = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic              clock,
  input  logic              rstn,
  fifo_hex_display_if.slave bus_io
);
  localparam longint unsigned HOLD_RAW   = (64'(CLK_FREQ) / 64'd1000) * 64'(HOLD_PERIOD);
  localparam longint unsigned HOLD_TICKS = (HOLD_RAW == 64'd0) ? 64'd1 : HOLD_RAW;
  localparam int              CNT_W      = $clog2(HOLD_TICKS) + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 64'd1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             rdreq_q, rdreq_d;
  logic [15:0]      data_q, data_d;
  logic             valid_q, valid_d;
  logic [7:0]       count_q, count_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  // Active-low glyph for one nibble.
  function automatic logic [6:0] seg_code_low(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0: code = 7'h40;
      4'h1: code = 7'h79;
      4'h2: code = 7'h24;
      4'h3: code = 7'h30;
      4'h4: code = 7'h19;
      4'h5: code = 7'h12;
      4'h6: code = 7'h02;
      4'h7: code = 7'h78;
      4'h8: code = 7'h00;
      4'h9: code = 7'h10;
      4'hA: code = 7'h08;
      4'hB: code = 7'h03;
      4'hC: code = 7'h46;
      4'hD: code = 7'h21;
      4'hE: code = 7'h06;
      4'hF: code = 7'h0E;
      default: code = 7'h7F;
    endcase
    return code;
  endfunction

  function automatic logic [6:0] seg_out(input logic [3:0] nib, input logic show);
    logic [6:0] low;
    if (show) begin
      low = seg_code_low(nib);
    end else begin
      low = 7'h7F;
    end
    return SEG_ACTIVE_LOW ? low : ~low;
  endfunction

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      rdreq_q <= 1'b0;
      data_q  <= 16'h0000;
      valid_q <= 1'b0;
      count_q <= 8'h00;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      rdreq_q <= rdreq_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic; enable and empty are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    rdreq_d = 1'b0;
    data_d  = data_q;
    valid_d = valid_q;
    count_d = count_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_io.enable && !bus_io.fifo_empty) begin
          rdreq_d = 1'b1;
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        data_d  = bus_io.fifo_q;
        valid_d = 1'b1;
        count_d = count_q + 8'd1;
        hold_d  = '0;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          hold_d  = '0;
          state_d = ST_IDLE;
        end else begin
          hold_d  = hold_q + CNT_W'(1'b1);
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus_io.fifo_rdreq = rdreq_q;
  assign bus_io.word_valid = valid_q;
  assign bus_io.word_count = count_q;
  assign bus_io.hex0       = seg_out(data_q[3:0],   valid_q);
  assign bus_io.hex1       = seg_out(data_q[7:4],   valid_q);
  assign bus_io.hex2       = seg_out(data_q[11:8],  valid_q);
  assign bus_io.hex3       = seg_out(data_q[15:12], valid_q);
endmodule
